// File: rtl/clmulctrl_pkg.sv
// Shared BMU definitions: carry-less multiply function encodings.
package clmulctrl_pkg;

    localparam logic [1:0] CLMUL  = 2'b00;
    localparam logic [1:0] CLMULH = 2'b01;
    localparam logic [1:0] CLMULR = 2'b10;

endpackage

// File: rtl/clmulstep.sv
// One carry-less multiply slice: XOR of (xs << k) over the set bits k of a STEP-bit multiplier slice.
module clmulstep #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 8
) (
    input  logic [2*WIDTH-1:0] xs,
    input  logic [STEP-1:0]    ys,
    output logic [2*WIDTH-1:0] prod
);

    always_comb begin
        prod = '0;
        for (int k = 0; k < STEP; k++) begin
            if (ys[k]) begin
                prod = prod ^ (xs << k);
            end
        end
    end

endmodule

// File: rtl/clmulctrl.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr) consuming STEP multiplier bits per cycle,
// with valid/ready handshakes on both sides and a flush input.
module clmulctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidIn,
    output logic             ReadyOut,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       Funct,
    input  logic             Flush,
    output logic             ValidOut,
    input  logic             ReadyIn,
    output logic [WIDTH-1:0] Result,
    output logic             Busy
);
    import clmulctrl_pkg::*;

    if ((WIDTH != 32 && WIDTH != 64) || STEP == 0 || (WIDTH % STEP) != 0) begin : gen_bad_params
        $error("clmulctrl: illegal WIDTH/STEP combination");
    end

    localparam int unsigned NSTEPS = WIDTH / STEP;
    localparam int unsigned CNTW   = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(NSTEPS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t               state_q, state_d;
    logic                 accept;
    logic [2*WIDTH-1:0]   xs_q, acc_q, prod;
    logic [WIDTH-1:0]     ys_q;
    logic [1:0]           funct_q;
    logic [CNTW-1:0]      cnt_q;

    clmulstep #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .xs   (xs_q),
        .ys   (ys_q[STEP-1:0]),
        .prod (prod)
    );

    assign accept = ValidIn & ReadyOut & ~Flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (accept) state_d = StRun;
                StRun:   if (cnt_q == '0) state_d = StDone;
                StDone:  if (ReadyIn) state_d = accept ? StRun : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        ReadyOut = (state_q == StIdle) | ((state_q == StDone) & ReadyIn);
        Busy     = (state_q == StRun);
        ValidOut = (state_q == StDone);
        Result   = '0;
        if (state_q == StDone) begin
            case (funct_q)
                CLMULH:  Result = acc_q[2*WIDTH-1:WIDTH];
                CLMULR:  Result = acc_q[2*WIDTH-2:WIDTH-1];
                default: Result = acc_q[WIDTH-1:0]; // CLMUL and reserved 2'b11
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xs_q    <= '0;
            ys_q    <= '0;
            funct_q <= CLMUL;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (Flush) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            xs_q    <= {{WIDTH{1'b0}}, X};
            ys_q    <= Y;
            funct_q <= Funct;
            acc_q   <= '0;
            cnt_q   <= CNT_LOAD;
        end else if (state_q == StRun) begin
            acc_q <= acc_q ^ prod;
            xs_q  <= xs_q << STEP;
            ys_q  <= ys_q >> STEP;
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_clmulctrl.sv
// Self-checking bench for clmulctrl (WIDTH=32, STEP=8): directed corner cases plus random operations
// checked against a bit-serial carry-less product model.
module tb_clmulctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ValidIn = 1'b0;
    logic        ReadyOut;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic [1:0]  Funct = '0;
    logic        Flush = 1'b0;
    logic        ValidOut;
    logic        ReadyIn = 1'b1;
    logic [31:0] Result;
    logic        Busy;

    int checks = 0;
    int failures = 0;

    clmulctrl #(
        .WIDTH (32),
        .STEP  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ValidIn  (ValidIn),
        .ReadyOut (ReadyOut),
        .X        (X),
        .Y        (Y),
        .Funct    (Funct),
        .Flush    (Flush),
        .ValidOut (ValidOut),
        .ReadyIn  (ReadyIn),
        .Result   (Result),
        .Busy     (Busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] f);
        logic [63:0] p = '0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) p = p ^ ({32'b0, a} << i);
        end
        case (f)
            2'b01:   return p[63:32];
            2'b10:   return p[62:31];
            default: return p[31:0];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the accept edge; returns edges taken to reach ValidOut.
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        chk({tag, "_busy"}, Busy, 1);
        while (!ValidOut && lat < 20) begin
            chk({tag, "_res0"}, Result, 0);
            step();
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [1:0] f, input logic [31:0] exp, input int stall);
        int lat;
        logic [31:0] held;
        ValidIn = 1'b1; X = x; Y = y; Funct = f; ReadyIn = 1'b1;
        #1 chk({tag, "_rdyout"}, ReadyOut, 1);
        step();
        ValidIn = 1'b0; X = $urandom; Y = $urandom; Funct = 2'($urandom);
        ReadyIn = (stall == 0);
        wait_done(tag, lat);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_result"}, Result, exp);
        held = Result;
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_readyout_stall"}, ReadyOut, 0);
            step();
            chk({tag, "_hold_valid"}, ValidOut, 1);
            chk({tag, "_hold_result"}, Result, held);
        end
        ReadyIn = 1'b1;
        step();
        chk({tag, "_idle_valid"}, ValidOut, 0);
        chk({tag, "_idle_res"}, Result, 0);
        chk({tag, "_idle_rdy"}, ReadyOut, 1);
    endtask

    task automatic abort_check(input string tag);
        int pulses = 0;
        chk({tag, "_valid"}, ValidOut, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_rdyout"}, ReadyOut, 1);
        chk({tag, "_res0"}, Result, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            if (ValidOut) pulses++;
        end
        chk({tag, "_nopulse"}, pulses, 0);
    endtask

    initial begin
        logic [31:0] xa, ya, xb, yb;
        logic [1:0]  fa;
        int          lat;

        step();
        step();
        reset = 1'b0;
        chk("reset_valid", ValidOut, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_result", Result, 0);
        chk("reset_rdyout", ReadyOut, 1);

        do_op("basic", 32'h3, 32'h3, 2'b00, 32'h5, 0);
        do_op("hi_lo", 32'h8000_0000, 32'h2, 2'b00, 32'h0, 0);
        do_op("hi_hi", 32'h8000_0000, 32'h2, 2'b01, 32'h1, 0);
        do_op("msb_h", 32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 0);
        do_op("msb_r", 32'h8000_0000, 32'h8000_0000, 2'b10, 32'h8000_0000, 0);
        do_op("resv", 32'hdead_beef, 32'h1234_5678, 2'b11,
              model(32'hdead_beef, 32'h1234_5678, 2'b00), 1);

        // Stall in DONE, then back-to-back accept as ReadyIn rises.
        xa = 32'h1234_5678; ya = 32'h9abc_def0;
        xb = 32'h0f0f_1111; yb = 32'h8000_0101;
        ValidIn = 1'b1; X = xa; Y = ya; Funct = 2'b10;
        step();
        ValidIn = 1'b0; ReadyIn = 1'b0;
        wait_done("b2b_a", lat);
        chk("b2b_a_lat", lat, 4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b2b_hold_valid", ValidOut, 1);
            chk("b2b_hold_result", Result, model(xa, ya, 2'b10));
        end
        ValidIn = 1'b1; X = xb; Y = yb; Funct = 2'b01; ReadyIn = 1'b1;
        #1 chk("b2b_rdyout", ReadyOut, 1);
        step();
        ValidIn = 1'b0;
        chk("b2b_b_valid_low", ValidOut, 0);
        wait_done("b2b_b", lat);
        chk("b2b_b_lat", lat, 4);
        chk("b2b_b_result", Result, model(xb, yb, 2'b01));
        step();
        chk("b2b_b_idle", ValidOut, 0);

        // Flush in the second RUN cycle.
        ValidIn = 1'b1; X = 32'h7; Y = 32'h7; Funct = 2'b00;
        step();
        ValidIn = 1'b0;
        step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        abort_check("flush_run");
        do_op("after_flush", 32'h5, 32'h3, 2'b00, 32'hf, 0);

        // Reset in the second RUN cycle.
        ValidIn = 1'b1; X = 32'h9; Y = 32'hb; Funct = 2'b00;
        step();
        ValidIn = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        abort_check("reset_run");
        do_op("after_reset", 32'h5, 32'h3, 2'b00, 32'hf, 0);

        // Flush in DONE beats a simultaneous accept and ReadyIn.
        ValidIn = 1'b1; X = 32'h3; Y = 32'h5; Funct = 2'b00;
        step();
        ValidIn = 1'b0; ReadyIn = 1'b0;
        wait_done("flush_done", lat);
        chk("flush_done_valid", ValidOut, 1);
        ValidIn = 1'b1; ReadyIn = 1'b1; Flush = 1'b1;
        step();
        ValidIn = 1'b0; Flush = 1'b0;
        abort_check("flush_done");

        // Flush in IDLE beats accept.
        ValidIn = 1'b1; Flush = 1'b1;
        step();
        ValidIn = 1'b0; Flush = 1'b0;
        chk("flush_idle_busy", Busy, 0);

        for (int n = 0; n < 24; n++) begin
            xa = $urandom; ya = $urandom; fa = 2'($urandom);
            do_op("rand", xa, ya, fa, model(xa, ya, fa), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
